// File: rtl/scaler_step_ctrl_if.sv
// Bundle of the video measurement inputs, output-size registers and the
// scaler-facing step outputs of scaler_step_ctrl.
// The video stream has no backpressure: de_i/hs_i/vs_i are sampled every clk.
// upd_o is a one-cycle qualifier that marks a new set of step outputs; the
// consumer must not stall it, and the three step outputs hold until the next
// upd_o.
interface scaler_step_ctrl_if;
    logic        de_i;
    logic        hs_i;
    logic        vs_i;
    logic [15:0] reg_out_width;
    logic [15:0] reg_out_height;
    logic [15:0] h_scale_step_o;
    logic [15:0] v_scale_step_o;
    logic [15:0] inline_size_o;
    logic        upd_o;
    logic        busy_o;
    logic        sat_o;
    logic        err_o;
    logic [2:0]  dbg_state;

    // Controller side.
    modport slave (
        input  de_i, hs_i, vs_i, reg_out_width, reg_out_height,
        output h_scale_step_o, v_scale_step_o, inline_size_o,
        output upd_o, busy_o, sat_o, err_o, dbg_state
    );

    // Video source / register block side.
    modport master (
        output de_i, hs_i, vs_i, reg_out_width, reg_out_height,
        input  h_scale_step_o, v_scale_step_o, inline_size_o,
        input  upd_o, busy_o, sat_o, err_o, dbg_state
    );
endinterface

// File: rtl/scaler_step_ctrl.sv
// Per-frame step controller for the bicubic scaler: measures the input frame,
// then computes floor(in * SCALE_STEP / out) for both axes with one shared
// restoring divider and presents the results to the scaler.
module scaler_step_ctrl #(
    parameter int SCALE_STEP = 4096,
    parameter int DIV_CYCLES = 32
) (
    input logic               clk,
    input logic               rst_n,
    scaler_step_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        DIV_H  = 3'd2,
        DIV_V  = 3'd3,
        UPDATE = 3'd4
    } state_t;

    localparam logic [31:0] STEP32   = 32'(SCALE_STEP);
    localparam logic [15:0] STEP16   = 16'(SCALE_STEP);
    localparam int          CW       = $clog2(DIV_CYCLES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DIV_CYCLES - 1);

    state_t state, state_nxt;

    // Edge detection and measurement
    logic        hs_prev, vs_prev;
    logic        hs_fall, vs_rise, line_close;
    logic [15:0] pix_cnt, line_cnt, last_w, line_inc;
    logic [15:0] meas_w, meas_h;

    // Divider and results
    logic [15:0] out_w, out_h, div_den;
    logic [31:0] div_num, num_nxt;
    logic [15:0] div_rem, rem_nxt;
    logic [16:0] trial;
    logic        trial_ge;
    logic [CW-1:0] div_cnt;
    logic [31:0] h_q, v_q;
    logic        h_sat, v_sat;
    logic [15:0] h_clamp, v_clamp;

    // Output registers
    logic [15:0] h_out, v_out, inline_out;
    logic        upd_r, sat_r, err_r;

    // FSM decode
    logic busy, div_run, div_last, upd_fire, latch_go, latch_fail, latch_bad;

    assign hs_fall    = hs_prev & ~bus.hs_i;
    assign vs_rise    = ~vs_prev & bus.vs_i;
    // A line only counts once it has carried at least one pixel.
    assign line_close = (hs_fall | vs_rise) && (pix_cnt != 16'd0);
    assign line_inc   = (line_cnt == 16'hFFFF) ? line_cnt : line_cnt + 16'd1;

    // A zero size on either side makes the step meaningless.
    assign latch_bad  = (meas_w == 16'd0) || (meas_h == 16'd0) ||
                        (bus.reg_out_width == 16'd0) || (bus.reg_out_height == 16'd0);

    // One restoring-division step: bring in the next numerator bit MSB first.
    assign div_den  = (state == DIV_V) ? out_h : out_w;
    assign trial    = {div_rem, div_num[31]};
    assign trial_ge = trial >= {1'b0, div_den};
    assign rem_nxt  = trial_ge ? 16'(trial - {1'b0, div_den}) : trial[15:0];
    assign num_nxt  = {div_num[30:0], trial_ge};

    assign h_sat   = |h_q[31:16];
    assign v_sat   = |v_q[31:16];
    assign h_clamp = h_sat ? 16'hFFFF : h_q[15:0];
    assign v_clamp = v_sat ? 16'hFFFF : v_q[15:0];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; a new frame start always restarts the computation.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vs_rise) state_nxt = LATCH;
            LATCH:   if (vs_rise) state_nxt = LATCH;
                     else if (latch_bad) state_nxt = IDLE;
                     else state_nxt = DIV_H;
            DIV_H:   if (vs_rise) state_nxt = LATCH;
                     else if (div_cnt == LAST_CNT) state_nxt = DIV_V;
            DIV_V:   if (vs_rise) state_nxt = LATCH;
                     else if (div_cnt == LAST_CNT) state_nxt = UPDATE;
            UPDATE:  if (vs_rise) state_nxt = LATCH;
                     else state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state control strobes.
    always_comb begin
        busy       = 1'b0;
        div_run    = 1'b0;
        div_last   = 1'b0;
        upd_fire   = 1'b0;
        latch_go   = 1'b0;
        latch_fail = 1'b0;
        case (state)
            LATCH: begin
                busy       = 1'b1;
                latch_go   = ~vs_rise & ~latch_bad;
                latch_fail = ~vs_rise & latch_bad;
            end
            DIV_H, DIV_V: begin
                busy     = 1'b1;
                div_run  = 1'b1;
                div_last = (div_cnt == LAST_CNT);
            end
            UPDATE: begin
                busy     = 1'b1;
                upd_fire = ~vs_rise;
            end
            default: ;
        endcase
    end

    // Sync edge history and frame measurement, running in every state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_prev  <= 1'b0;
            vs_prev  <= 1'b0;
            pix_cnt  <= 16'd0;
            line_cnt <= 16'd0;
            last_w   <= 16'd0;
            meas_w   <= 16'd0;
            meas_h   <= 16'd0;
        end else begin
            hs_prev <= bus.hs_i;
            vs_prev <= bus.vs_i;
            if (line_close) begin
                last_w   <= pix_cnt;
                line_cnt <= line_inc;
                pix_cnt  <= 16'd0;
            end else if (bus.de_i && (pix_cnt != 16'hFFFF)) begin
                pix_cnt <= pix_cnt + 16'd1;
            end
            // Frame start publishes the measurement, including a last line
            // that never saw an hs falling edge.
            if (vs_rise) begin
                meas_w   <= line_close ? pix_cnt : last_w;
                meas_h   <= line_close ? line_inc : line_cnt;
                line_cnt <= 16'd0;
                pix_cnt  <= 16'd0;
                last_w   <= 16'd0;
            end
        end
    end

    // Divider datapath, result clamping and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_w      <= 16'd0;
            out_h      <= 16'd0;
            div_num    <= 32'd0;
            div_rem    <= 16'd0;
            div_cnt    <= '0;
            h_q        <= 32'd0;
            v_q        <= 32'd0;
            h_out      <= STEP16;
            v_out      <= STEP16;
            inline_out <= 16'd0;
            upd_r      <= 1'b0;
            sat_r      <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            upd_r <= upd_fire;
            if (state == LATCH) begin
                out_w <= bus.reg_out_width;
                out_h <= bus.reg_out_height;
            end
            if (latch_go) begin
                div_num <= {16'd0, meas_w} * STEP32;
                div_rem <= 16'd0;
                div_cnt <= '0;
            end
            if (div_run) begin
                div_num <= num_nxt;
                div_rem <= rem_nxt;
                div_cnt <= div_cnt + 1'b1;
            end
            // Horizontal done: keep the quotient and reuse the divider vertically.
            if (div_last && (state == DIV_H)) begin
                h_q     <= num_nxt;
                div_num <= {16'd0, meas_h} * STEP32;
                div_rem <= 16'd0;
                div_cnt <= '0;
            end
            if (div_last && (state == DIV_V)) v_q <= num_nxt;
            if (latch_fail) err_r <= 1'b1;
            if (upd_fire) begin
                h_out      <= h_clamp;
                v_out      <= v_clamp;
                inline_out <= meas_w;
                if (h_sat || v_sat) sat_r <= 1'b1;
            end
        end
    end

    assign bus.h_scale_step_o = h_out;
    assign bus.v_scale_step_o = v_out;
    assign bus.inline_size_o  = inline_out;
    assign bus.upd_o          = upd_r;
    assign bus.busy_o         = busy;
    assign bus.sat_o          = sat_r;
    assign bus.err_o          = err_r;
    assign bus.dbg_state      = state;

endmodule

// File: tb/tb_scaler_step_ctrl.sv
// Testbench for scaler_step_ctrl: drives synthetic frames, predicts each step
// update from the frame geometry with plain arithmetic and checks the updates,
// their timing and the sticky flags.
module tb_scaler_step_ctrl;

    localparam int SCALE_STEP = 4096;
    // Cycles from driving vs_i high to the cycle upd_o is observed.
    localparam int UPD_LAT = 67;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    scaler_step_ctrl_if bus();

    scaler_step_ctrl #(.SCALE_STEP(SCALE_STEP), .DIV_CYCLES(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    // Entry: {h_step, v_step, inline_size, expected upd cycle}
    logic [79:0] exp_q[$];
    logic [79:0] item;
    int checks = 0;
    int errors = 0;
    int pend_w = 0;     // width of last active line since previous vs
    int pend_h = 0;     // active lines since previous vs
    logic exp_sat = 1'b0;
    logic exp_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference step: floor(in * SCALE_STEP / out), clamped to 16 bits.
    function automatic logic [15:0] ref_step(input int in_sz, input int out_sz, inout logic sat);
        longint q;
        q = (longint'(in_sz) * SCALE_STEP) / out_sz;
        if (q > 65535) begin
            sat = 1'b1;
            return 16'hFFFF;
        end
        return 16'(q);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && bus.upd_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_upd: upd_o=1 with no update expected at cycle %0d", cyc);
            end else begin
                item = exp_q.pop_front();
                check("h_step",     32'(bus.h_scale_step_o), 32'(item[79:64]));
                check("v_step",     32'(bus.v_scale_step_o), 32'(item[63:48]));
                check("inline",     32'(bus.inline_size_o),  32'(item[47:32]));
                check("upd_cycle",  32'(cyc),                item[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.de_i = 1'b0;
        bus.hs_i = 1'b0;
        bus.vs_i = 1'b0;
        tick(3);
        exp_q.delete();
        pend_w = 0;
        pend_h = 0;
        exp_sat = 1'b0;
        exp_err = 1'b0;
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic drive_line(input int w, input bit with_hs);
        for (int i = 0; i < w; i++) begin
            bus.de_i = 1'b1;
            tick();
        end
        bus.de_i = 1'b0;
        if (with_hs) begin
            bus.hs_i = 1'b1;
            tick();
            bus.hs_i = 1'b0;
            tick();
        end
        if (w > 0) begin
            pend_h++;
            pend_w = w;
        end
    endtask

    task automatic drive_frame(input int w, input int h);
        for (int l = 0; l < h; l++) drive_line(w, 1'b1);
    endtask

    // Frame start: predicts the result of the just-measured frame.
    task automatic issue_vs(input int ow, input int oh, input bit expect_run = 1'b1,
                            input int wait_after = 75);
        logic [15:0] h, v;
        int vs_cyc;
        bus.reg_out_width  = 16'(ow);
        bus.reg_out_height = 16'(oh);
        bus.vs_i = 1'b1;
        vs_cyc = cyc;
        if (expect_run) begin
            if (pend_w == 0 || pend_h == 0 || ow == 0 || oh == 0) begin
                exp_err = 1'b1;
            end else begin
                h = ref_step(pend_w, ow, exp_sat);
                v = ref_step(pend_h, oh, exp_sat);
                exp_q.push_back({h, v, 16'(pend_w), 32'(vs_cyc + UPD_LAT)});
            end
        end
        pend_w = 0;
        pend_h = 0;
        tick();
        bus.vs_i = 1'b0;
        tick(wait_after - 1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_outs(input string tag, input int h, input int v, input int w);
        check({tag, "_h"},      32'(bus.h_scale_step_o), 32'(h));
        check({tag, "_v"},      32'(bus.v_scale_step_o), 32'(v));
        check({tag, "_inline"}, 32'(bus.inline_size_o),  32'(w));
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_sat"}, 32'(bus.sat_o), 32'(exp_sat));
        check({tag, "_err"}, 32'(bus.err_o), 32'(exp_err));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w, h, ow, oh, lw;
        bus.de_i = 1'b0;
        bus.hs_i = 1'b0;
        bus.vs_i = 1'b0;
        bus.reg_out_width  = 16'd0;
        bus.reg_out_height = 16'd0;
        do_reset();

        // No video at all: reset values hold, no update.
        tick(1000);
        check_outs("idle", 4096, 4096, 0);
        check("idle_busy", 32'(bus.busy_o), 32'd0);
        check_flags("idle");

        // Downscale 3:2 on both axes, several frames.
        for (int f = 0; f < 3; f++) begin
            drive_frame(96, 54);
            issue_vs(64, 36);
        end
        drain();
        check_outs("down32", 6144, 6144, 96);
        check_flags("down32");

        // Upscale: fractional steps floor.
        do_reset();
        drive_frame(64, 48);
        issue_vs(192, 108);
        drain();
        check_outs("up", 1365, 1820, 64);
        check("up_sat", 32'(bus.sat_o), 32'd0);
        check("up_err", 32'(bus.err_o), 32'd0);

        // Saturation, then zero output width.
        do_reset();
        drive_frame(1024, 8);
        issue_vs(1, 8);
        drain();
        check_outs("sat", 16'hFFFF, 4096, 1024);
        check("sat_flag_set", 32'(bus.sat_o), 32'd1);
        drive_frame(16, 4);
        issue_vs(0, 8);
        tick(80);
        check_outs("zero_w", 16'hFFFF, 4096, 1024);
        check("zero_w_err", 32'(bus.err_o), 32'd1);
        check_flags("zero_w");

        // Abort 10 cycles into the horizontal division.
        do_reset();
        drive_frame(20, 10);
        issue_vs(8, 4, 1'b0, 12);
        issue_vs(8, 4);
        drive_frame(16, 8);
        issue_vs(8, 4);
        drain();
        check_outs("abort", 8192, 8192, 16);
        check_flags("abort");

        // Reset during the vertical division.
        drive_frame(16, 8);
        issue_vs(4, 4, 1'b0, 45);
        do_reset();
        check_outs("rst_div", 4096, 4096, 0);
        check("rst_div_busy", 32'(bus.busy_o), 32'd0);
        tick(100);
        check_flags("rst_div");

        // Last line closed by vs only, then ragged lines.
        drive_frame(16, 7);
        drive_line(16, 1'b0);
        issue_vs(16, 8);
        drain();
        check_outs("nohs", 4096, 4096, 16);
        drive_line(16, 1'b1);
        drive_line(16, 1'b1);
        drive_line(12, 1'b1);
        issue_vs(6, 2);
        drain();
        check_outs("ragged", 8192, 6144, 12);

        // Randomized frames: per-line widths (some empty), random out sizes.
        do_reset();
        for (int f = 0; f < 20; f++) begin
            h = $urandom_range(1, 12);
            for (int l = 0; l < h; l++) begin
                lw = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24);
                drive_line(lw, (l != h - 1) || ($urandom_range(0, 1) == 1));
            end
            w  = $urandom_range(0, 9);
            ow = (w == 0) ? 0 : $urandom_range(1, 64);
            oh = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 32);
            issue_vs(ow, oh);
        end
        drain();
        check_flags("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scaler_step_ctrl.md
Name: scaler_step_ctrl

Overview:
- Per-frame configuration controller for the bicubic scaler.
- Measures the active input frame size from the de/hs/vs stream.
- Computes h/v scale steps as floor(in_size * SCALE_STEP / out_size) with a shared sequential divider.
- Drives the scaler's reg_h_scale_step, reg_v_scale_step and reg_v_scale_inline_size inputs; the scaler samples them at its next frame start.

Parameters:
- SCALE_STEP, 4096, fixed-point unity step; must match the scaler's SCALE_STEP; legal range 1..65535.
- DIV_CYCLES, 32, quotient bits produced per division, one bit per clock.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- de_i  in  1  input pixel valid.
- hs_i  in  1  input line sync; falling edge ends a line.
- vs_i  in  1  input frame sync; rising edge starts a frame.
- reg_out_width  in  16  target output width, pixels.
- reg_out_height  in  16  target output height, lines.
- h_scale_step_o  out  16  to scaler reg_h_scale_step.
- v_scale_step_o  out  16  to scaler reg_v_scale_step.
- inline_size_o  out  16  to scaler reg_v_scale_inline_size; measured input width.
- upd_o  out  1  one-cycle pulse when the three outputs change.
- busy_o  out  1  high from LATCH through UPDATE inclusive.
- sat_o  out  1  sticky; a step saturated to 0xFFFF.
- err_o  out  1  sticky; out size 0 or no video measured.

Behaviour:
- Reset values (rst_n=0 at a clk edge):
  - h_scale_step_o, v_scale_step_o = SCALE_STEP[15:0]; inline_size_o = 0.
  - upd_o, busy_o, sat_o, err_o = 0; FSM = IDLE; all counters cleared.
  - Reset mid-division aborts it; outputs return to reset values.
- Edge detect: registered copies of hs_i and vs_i. hs_fall = prev & !hs_i; vs_rise = !prev & vs_i.
- Measurement:
  - pix_cnt counts de_i cycles within a line, saturating at 0xFFFF.
  - A line is "active" if pix_cnt != 0. It closes at hs_fall or vs_rise, whichever comes first.
  - On close of an active line: last_w <= pix_cnt; line_cnt++ (saturating); pix_cnt <= 0.
  - On vs_rise, after closing any pending line: meas_w <= last_w; meas_h <= line_cnt; line_cnt, pix_cnt, last_w <= 0.
- Out sizes: reg_out_width and reg_out_height are sampled into out_w/out_h in the LATCH cycle only.
- FSM states: IDLE, LATCH, DIV_H, DIV_V, UPDATE.
  - IDLE -> LATCH on vs_rise.
  - LATCH (1 cycle):
    - If meas_w==0, meas_h==0, out_w==0 or out_h==0: set err_o, go to IDLE, outputs unchanged, no upd_o.
    - Otherwise load divider with numerator meas_w*SCALE_STEP (32 bit) and divisor out_w.
  - DIV_H: exactly DIV_CYCLES cycles of restoring division, MSB first; then result into h_q.
  - DIV_V: same with meas_h*SCALE_STEP / out_h; result into v_q.
  - UPDATE (1 cycle):
    - Each quotient above 0xFFFF is clamped to 0xFFFF and sets sat_o.
    - Outputs register at the end of UPDATE; inline_size_o <= meas_w.
    - upd_o is high in the following cycle; then IDLE.
- Latency: outputs and upd_o valid 2*DIV_CYCLES+2 cycles after the cycle where the FSM leaves IDLE.
- vs_rise while busy: abort the current computation (no upd_o), restart at LATCH with the new measurement. Measurement counters keep running in every state.
- Sticky flags: sat_o and err_o clear only on reset. Rounding is floor, no rounding bit.
- Outputs are stable between updates. Frame N's steps reach the scaler at frame N+1's vs.

Test Plan:
- Reset, no video for 1000 cycles -> h/v = 4096, inline_size_o = 0, upd_o never high, busy_o = 0.
- Frames of 1920 de per line x 1080 lines, out 1280x720 -> upd_o once per frame; h = v = 6144; inline_size_o = 1920; upd_o exactly 66 cycles after IDLE exit.
- 640x480 in, out 1920x1080 -> h = 1365, v = 1820; sat_o = 0, err_o = 0.
- 1024x8 in, out 1x8 -> h = 0xFFFF, sat_o = 1, v = 4096; reg_out_width = 0 next frame -> err_o = 1, outputs keep the previous values, no upd_o.
- vs_rise 10 cycles into DIV_H, then 16x8 in, out 8x4 -> no upd_o for the aborted run; one upd_o with h = v = 8192. In another run, rst_n low during DIV_V -> outputs return to reset values, busy_o = 0.
- Last line with no hs fall before vs_rise, 16x8 in -> meas_h = 8, inline_size_o = 16. Ragged lines 16,16,12 -> inline_size_o = 12.
